// File: rtl/encode_immediate.sv
// encode_immediate: inverse of the immediate extender. Given a 32-bit constant
// and an ImmSrc format, it reports whether the constant fits that format and
// returns the packed instruction field. The rotated-imm8 format walks the 16
// rotate amounts one per clock, so the smallest hitting rotation wins.
module encode_immediate #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] value,
    input  logic [1:0]   ImmSrc,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [23:0]  field
);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   val_q;
    logic [1:0]     mode_q;
    logic [3:0]     rot;
    logic [2*W-1:0] dbl;
    logic [W-1:0]   rotc;
    logic           hit;
    logic           fin;
    logic [23:0]    field_nx;
    logic           accept;

    assign accept = (state == IDLE) && start;

    // Rotate-left by 2*rot: shifting the doubled word leaves the rotation in the upper half.
    always_comb begin
        dbl  = {val_q, val_q} << {rot, 1'b0};
        rotc = dbl[2*W-1:W];
    end

    // Resolve the current SEARCH cycle: hit/finish and the field to publish.
    always_comb begin
        hit      = 1'b0;
        fin      = 1'b1;
        field_nx = '0;
        case (mode_q)
            2'b00: begin
                hit = (rotc[31:8] == '0);
                fin = hit || (rot == 4'd15);
                if (hit) field_nx = {12'b0, rot, rotc[7:0]};
            end
            2'b01: begin
                hit = (val_q[31:12] == '0);
                if (hit) field_nx = {12'b0, val_q[11:0]};
            end
            2'b10: begin
                // Sign bits 31..23 must agree for a 24-bit signed field.
                hit = (&val_q[31:23]) || (~|val_q[31:23]);
                if (hit) field_nx = val_q[23:0];
            end
            default: begin
                hit = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: accept only when idle, return to idle when the search resolves.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEARCH;
            SEARCH:  if (fin)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: busy spans exactly the SEARCH state.
    always_comb begin
        busy = (state == SEARCH);
    end

    // Operand latch, rotate counter and registered result/done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q  <= '0;
            mode_q <= 2'b00;
            rot    <= 4'd0;
            done   <= 1'b0;
            valid  <= 1'b0;
            field  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                val_q  <= value;
                mode_q <= ImmSrc;
                rot    <= 4'd0;
            end else if (state == SEARCH) begin
                if (fin) begin
                    done  <= 1'b1;
                    valid <= hit;
                    field <= field_nx;
                end else begin
                    rot <= rot + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_encode_immediate.sv
// Bench for encode_immediate: directed corner cases plus random requests,
// each compared with a reference model computed straight from the format rules.
module tb_encode_immediate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic [1:0]  ImmSrc = 2'b00;
    logic        busy, done, valid;
    logic [23:0] field;

    int total = 0;
    int bad   = 0;

    encode_immediate #(.W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .ImmSrc(ImmSrc),
        .busy(busy), .done(done), .valid(valid), .field(field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: smallest rotation r with value rotl 2r < 256; ranges for the rest.
    function automatic void model(input logic [31:0] v, input logic [1:0] m,
                                  output logic ok, output logic [23:0] f, output int lat);
        logic [31:0] c;
        int          sv;
        ok = 1'b0; f = '0; lat = 1;
        case (m)
            2'b00: begin
                lat = 16;
                for (int r = 0; r < 16; r++) begin
                    if (r == 0) c = v;
                    else        c = (v << (2*r)) | (v >> (32 - 2*r));
                    if (!ok && c < 256) begin
                        ok  = 1'b1;
                        f   = 24'(r * 256 + c);
                        lat = r + 1;
                    end
                end
            end
            2'b01: if (v < 32'd4096) begin ok = 1'b1; f = v[23:0]; end
            2'b10: begin
                sv = $signed(v);
                if (sv >= -8388608 && sv <= 8388607) begin ok = 1'b1; f = v[23:0]; end
            end
            default: ;
        endcase
    endfunction

    // Issue one request on the next edge and follow it to its done pulse.
    // poke: pulse start with a different request mid-search.
    task automatic run(input string tag, input logic [31:0] v, input logic [1:0] m, input bit poke);
        logic        eok;
        logic [23:0] ef;
        int          elat;
        int          k;
        bit          seen;
        model(v, m, eok, ef, elat);
        @(negedge clk);
        start = 1'b1; value = v; ImmSrc = m;
        @(posedge clk); #1;
        chk({tag, ".e0_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, ".e0_done"}, {31'b0, done}, 32'd0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            start  = poke && (k == 2);
            value  = $urandom;
            ImmSrc = 2'($urandom);
            @(posedge clk); #1;
            k++;
            if (done) seen = 1'b1;
            else if (busy !== 1'b1) chk({tag, ".busy_mid"}, {31'b0, busy}, 32'd1);
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, ".latency"}, 32'(k), 32'(elat));
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, eok});
        chk({tag, ".field"}, {8'b0, field}, {8'b0, ef});
        chk({tag, ".busy_end"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] rv;
        logic [1:0]  rm;
        int          gap;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy",  {31'b0, busy},  32'd0);
        chk("reset.done",  {31'b0, done},  32'd0);
        chk("reset.valid", {31'b0, valid}, 32'd0);
        chk("reset.field", {8'b0, field},  32'd0);
        @(negedge clk) reset = 1'b0;

        // Directed cases; consecutive runs start in the done cycle (back-to-back).
        run("m0_ab",      32'h0000_00AB, 2'b00, 1'b0);
        run("m0_ab_rot4", 32'hAB00_0000, 2'b00, 1'b0);
        run("m0_3fc",     32'h0000_03FC, 2'b00, 1'b0);
        run("m0_miss",    32'h0000_0101, 2'b00, 1'b0);
        run("m0_zero",    32'h0000_0000, 2'b00, 1'b0);
        run("m1_fff",     32'h0000_0FFF, 2'b01, 1'b0);
        run("m1_1000",    32'h0000_1000, 2'b01, 1'b0);
        run("m3",         32'h0000_0001, 2'b11, 1'b0);
        run("m2_neg",     32'hFF80_0000, 2'b10, 1'b0);
        run("m2_bad",     32'hFF7F_FFFF, 2'b10, 1'b0);
        run("m2_pos",     32'h007F_FFFF, 2'b10, 1'b0);
        run("m0_poke",    32'h0000_03FC, 2'b00, 1'b1);
        run("m1_b2b",     32'h0000_0123, 2'b01, 1'b0);

        // Reset part-way through a long search: no done, outputs cleared.
        @(negedge clk);
        start = 1'b1; value = 32'h0000_03FC; ImmSrc = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid.busy",  {31'b0, busy},  32'd0);
        chk("rst_mid.done",  {31'b0, done},  32'd0);
        chk("rst_mid.valid", {31'b0, valid}, 32'd0);
        chk("rst_mid.field", {8'b0, field},  32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done !== 1'b0) chk("rst_mid.no_done", {31'b0, done}, 32'd0);
        end
        chk("rst_mid.idle", {31'b0, busy}, 32'd0);

        // Random requests, biased toward encodable rotated bytes for mode 00.
        for (int i = 0; i < 40; i++) begin
            rm = 2'($urandom);
            case ($urandom_range(0, 3))
                0: rv = $urandom;
                1: begin
                    rv = {24'b0, 8'($urandom)};
                    gap = 2 * $urandom_range(0, 15);
                    if (gap != 0) rv = (rv << gap) | (rv >> (32 - gap));
                end
                2: rv = $urandom_range(0, 8191);
                default: rv = 32'($signed(24'($urandom)));
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            run("rand", rv, rm, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
